uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single USB->Serial transmit line (usb_tx) between NUM_REQ independent byte sources inside the top level.
- Grants one requester per byte using round-robin arbitration.
- Latches the granted byte and serializes it as 8N1 at BAUD.
- Replaces the direct usb_rx->usb_tx echo wiring once multiple blocks need to emit serial data.

Parameters:
- CLK_FREQ, 100000000: clock frequency in Hz.
- BAUD, 1000000: serial bit rate.
- NUM_REQ, 4: number of requesters (2..16).
- CLKS_PER_BIT, derived (not overridable): CLK_FREQ/BAUD, truncated integer divide. Must be >=2; elaboration error otherwise.

Ports:
- clk  input  1  system clock (100 MHz on the board).
- rst_n  input  1  synchronous, active-low reset. The top level drives it from its reset-conditioner output, inverted.
- req_data  input  NUM_REQ*8  byte for requester i at bits [8i+7:8i].
- req_valid  input  NUM_REQ  requester i has a byte pending; must hold data stable until accepted.
- req_ready  output  NUM_REQ  one-hot; byte i is accepted in the cycle where req_valid[i] && req_ready[i].
- tx  output  1  serial line; connects to usb_tx.
- busy  output  1  high while a frame is in START/DATA/STOP.
- grant_id  output  clog2(NUM_REQ)  index of the last accepted requester.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-low: sampled on the rising clk edge when rst_n==0.
- Reset values: tx=1, busy=0, req_ready=0, grant_id=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 wins first), bit counter=0, baud counter=0.
- State IDLE:
  - tx=1.
  - If any req_valid is set, req_ready is driven combinationally for exactly one index g. g is the first set req_valid searching ptr+1, ptr+2, ... with wrap-around modulo NUM_REQ.
  - On the edge: latch req_data[g], set ptr=g and grant_id=g, go to START.
  - No valid set: stay IDLE, req_ready=0.
- State START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- State DATA:
  - tx=shift[0], LSB first.
  - Each bit lasts CLKS_PER_BIT cycles; shift right after each bit.
  - After bit 7 completes, go to STOP.
- State STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- req_ready: 0 in every state except IDLE, so at most one accept per frame.
- busy: 1 in START/DATA/STOP, 0 in IDLE.
- Latency and throughput:
  - Start bit begins on tx the cycle after the accept.
  - Frame period with continuous requests is 10*CLKS_PER_BIT+1 cycles. The extra IDLE cycle is tx=1 and lengthens the stop bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears on every state change. No fractional-baud correction.
- Fairness: with all requesters valid, grants go 0,1,2,...,NUM_REQ-1,0,...
- Boundary cases:
  - A single valid requester is granted on every frame.
  - A requester dropping valid while not granted loses nothing; it is simply skipped.
  - req_data changing after the accept does not affect the frame in flight.
- Reset mid-frame: tx returns to 1 on the next edge and the partial frame is abandoned. The byte is not re-sent.
- req_ready has no combinational dependency on req_data. It depends only on req_valid, state and ptr.

Optional Feature:
- Macro: UART_TX_ARBITER_LOCK_EN.
- When defined:
  - Adds input req_lock [NUM_REQ].
  - If the requester accepted last has req_lock set and req_valid set in IDLE, it is granted again, ignoring round-robin.
  - Round-robin resumes from ptr once its lock or valid drops. This allows multi-byte messages to stay contiguous.
- When undefined: the port does not exist and arbitration is pure round-robin.

Test Plan (CLK_FREQ=100e6, BAUD=1e6, CLKS_PER_BIT=100, NUM_REQ=4):
1. Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5:
   - req_ready=4'b0001 for one cycle.
   - tx bits at 100-cycle spacing: 0,1,0,1,0,0,1,0,1,1.
   - busy high for 1000 cycles; grant_id=0.
2. All four valid with data 8'h10,8'h21,8'h32,8'h43:
   - Bytes appear on tx in order 10,21,32,43.
   - Frames are 1001 cycles apart; grant_id goes 0,1,2,3.
3. Only requester 2 valid continuously: every frame carries requester 2's data and grant_id stays 2.
4. rst_n=0 for one cycle during DATA bit 4:
   - tx=1 and busy=0 on the next edge.
   - req_ready=0 during the reset cycle.
   - The next accept goes to requester 0.
5. Change req_data[7:0] to 8'hFF one cycle after the accept of 8'h3C: tx still serializes 8'h3C.
6. With UART_TX_ARBITER_LOCK_EN, requester 1 locked and valid for 3 bytes, requester 3 valid throughout: grants go 1,1,1,3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one 8N1 serial transmit line between NUM_REQ byte sources.
//   A round-robin arbiter picks one requester per frame; the accepted byte
//   is latched and shifted out LSB first at CLK_FREQ/BAUD clocks per bit.
//
// Optional build macro: UART_TX_ARBITER_LOCK_EN
//   Adds req_lock. The last accepted requester keeps the line while its
//   lock and valid stay high, so multi-byte messages go out contiguously.
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   req_data   byte for requester i at [8i+7:8i]
//   req_valid  requester i has a byte pending (data held until accepted)
//   req_lock   (macro only) keep the grant on the last accepted requester
//   req_ready  one-hot accept strobe, only ever high in IDLE
//   tx         serial line, idles high
//   busy       high while a frame is in START/DATA/STOP
//   grant_id   index of the last accepted requester
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | line high, arbitrate, accept one byte when any valid
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx=1) for CLKS_PER_BIT cycles
module uart_tx_arbiter #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 1000000,
  parameter int NUM_REQ  = 4,
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_lock,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_arbiter: CLK_FREQ/BAUD must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be in 2..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;

  logic              any_valid;
  logic [ID_W-1:0]   rr_pick;
  logic [ID_W-1:0]   rr_idx;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic              accept;

  // Round-robin search starts just after the last winner and wraps.
  always_comb begin
    any_valid = 1'b0;
    rr_pick   = ptr;
    rr_idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!any_valid && req_valid[rr_idx]) begin
        any_valid = 1'b1;
        rr_pick   = rr_idx;
      end
    end
  end

`ifdef UART_TX_ARBITER_LOCK_EN
  // have_grant stops the reset value of ptr from looking like a real owner.
  logic have_grant;
  logic lock_hit;
  assign lock_hit  = have_grant && req_lock[ptr] && req_valid[ptr];
  assign grant_idx = lock_hit ? ptr : rr_pick;
`else
  assign grant_idx = rr_pick;
`endif

  always_comb begin
    grant_onehot = '0;
    grant_onehot[grant_idx] = 1'b1;
  end

  // Gated by rst_n so nothing is handed a phantom accept while reset holds
  // the FSM; no path from req_data.
  assign accept    = rst_n && (state == IDLE) && any_valid;
  assign req_ready = accept ? grant_onehot : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
      have_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (any_valid) begin
            shift_q  <= req_data[8*grant_idx +: 8];
            ptr      <= grant_idx;
            grant_id <= grant_idx;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
`ifdef UART_TX_ARBITER_LOCK_EN
            have_grant <= 1'b1;
`endif
          end
        end
        START: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_q[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift_q <= shift_q >> 1;
              // next bit is shift_q[1] before the shift lands
              tx      <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 100;
  localparam int FRAME   = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;
`ifdef UART_TX_ARBITER_LOCK_EN
  logic [3:0]  req_lock = '0;
`endif

  uart_tx_arbiter #(
    .CLK_FREQ(100000000),
    .BAUD    (1000000),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_data (req_data),
    .req_valid(req_valid),
`ifdef UART_TX_ARBITER_LOCK_EN
    .req_lock (req_lock),
`endif
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Requester side: each source owns a queue of bytes still to send.
  logic [7:0] q [NUM_REQ][$];
  bit         en [NUM_REQ];
  bit         rand_mode;
  logic [7:0] fill_byte;

  // Reference model of the serial line, in terms of "cycles since accept".
  int         m_ptr, m_gid, m_k;
  bit         m_in_frame, m_frame_end;
  logic [9:0] m_bits, obs_bits;
  int         busy_cnt, cyc;
  int         grants[$];
  int         acc_cyc[$];
  logic [7:0] rx_bytes[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [3:0]  v;
    logic [31:0] d;
    if (rand_mode) fill_byte = 8'($urandom);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rand_mode && $urandom_range(0, 99) < 3) en[i] = !en[i];
      v[i] = en[i] && (q[i].size() > 0);
      d[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : fill_byte;
    end
    req_valid = v;
    req_data  = d;
  endtask

  function automatic bit pending();
    bit p;
    p = m_in_frame || m_frame_end;
    for (int i = 0; i < NUM_REQ; i++) if (q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_in_frame  = 1'b0;
    m_frame_end = 1'b0;
    m_ptr       = NUM_REQ - 1;
    m_gid       = 0;
    busy_cnt    = 0;
  endtask

  // One clock: check at the falling edge, then update model and inputs
  // just after the rising edge.
  task automatic step();
    int         g;
    bit         acc;
    logic [3:0] exp_rdy;
    logic [7:0] b;
    acc = 1'b0;
    g   = 0;
    @(negedge clk);
    if (m_in_frame) begin
      if (busy) busy_cnt++;
      if (m_k == 0) begin
        chk("start_bit", tx, 0);
        chk("grant_id", grant_id, m_gid);
      end
      if (m_k % CPB == CPB / 2) begin
        obs_bits[m_k / CPB] = tx;
        chk("ready_in_frame", req_ready, 0);
      end
    end else begin
      if (m_frame_end) begin
        chk("busy_len", busy_cnt, FRAME);
        chk("rx_frame", obs_bits, m_bits);
        rx_bytes.push_back(obs_bits[8:1]);
        m_frame_end = 1'b0;
      end
      busy_cnt = 0;
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      exp_rdy = '0;
      for (int d = 1; d <= NUM_REQ; d++) begin
        int idx;
        idx = (m_ptr + d) % NUM_REQ;
        if (!acc && req_valid[idx]) begin
          acc = 1'b1;
          g   = idx;
        end
      end
      if (acc) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (acc) begin
        m_ptr  = g;
        m_gid  = g;
        b      = q[g].pop_front();
        m_bits = {1'b1, b, 1'b0};
        obs_bits = '0;
        grants.push_back(g);
        acc_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (m_in_frame) begin
      m_k++;
      if (m_k == FRAME) begin
        m_in_frame  = 1'b0;
        m_frame_end = 1'b1;
      end
    end
    if (acc) begin
      m_in_frame = 1'b1;
      m_k        = 0;
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", n < budget, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc += 2;
    model_reset();
  endtask

  logic [7:0] t2_bytes [4];
  int first;
  int n;

  initial begin
    t2_bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
    for (int i = 0; i < NUM_REQ; i++) en[i] = 1'b1;
    rand_mode = 1'b0;
    fill_byte = 8'h00;
    cyc       = 0;
    obs_bits  = '0;
    m_bits    = '0;
    m_k       = 0;
    req_valid = '0;
    req_data  = '0;
    rst_n     = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;

    // single byte A5 from requester 0
    q[0].push_back(8'hA5);
    drive();
    drain(3000);
    chk("frame_A5", obs_bits, 10'b1101001010);

    // all four requesters, fairness and back-to-back spacing
    do_reset();
    first = grants.size();
    for (int i = 0; i < NUM_REQ; i++) q[i].push_back(t2_bytes[i]);
    drive();
    drain(6000);
    for (int j = 0; j < NUM_REQ; j++) begin
      chk("rr_order", (grants.size() > first + j) ? grants[first + j] : -1, j);
      chk("rr_bytes", (rx_bytes.size() > first + j) ? rx_bytes[first + j] : 8'hxx, t2_bytes[j]);
    end
    for (int j = 1; j < NUM_REQ; j++)
      chk("frame_gap", (acc_cyc.size() > first + j) ?
          acc_cyc[first + j] - acc_cyc[first + j - 1] : -1, FRAME + 1);

    // lone requester 2
    first = grants.size();
    q[2].push_back(8'h5C);
    q[2].push_back(8'hC5);
    q[2].push_back(8'h01);
    drive();
    drain(4000);
    for (int j = 0; j < 3; j++)
      chk("lone_grant", (grants.size() > first + j) ? grants[first + j] : -1, 2);

    // reset during data bit 4; pointer must restart so requester 0 wins
    q[1].push_back(8'h5A);
    drive();
    n = 0;
    while (!(m_in_frame && m_k == 5 * CPB + 20) && n < 3000) begin
      step();
      n++;
    end
    chk("reach_bit4", n < 3000, 1);
    q[0].push_back(8'h66);
    q[2].push_back(8'h77);
    drive();
    rst_n = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", req_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    model_reset();
    first = grants.size();
    drain(5000);
    chk("post_reset_grant", (grants.size() > first) ? grants[first] : -1, 0);
    chk("post_reset_count", grants.size() - first, 2);

    // data changes right after accept must not reach the line
    fill_byte = 8'hFF;
    q[0].push_back(8'h3C);
    drive();
    drain(3000);
    chk("data_hold", (rx_bytes.size() > 0) ? rx_bytes[rx_bytes.size() - 1] : 8'hxx, 8'h3C);

    // randomized traffic with requesters dropping in and out
    for (int j = 0; j < 24; j++) q[$urandom_range(0, NUM_REQ - 1)].push_back(8'($urandom));
    rand_mode = 1'b1;
    for (int c = 0; c < 20000 && pending(); c++) step();
    rand_mode = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) en[i] = 1'b1;
    drive();
    drain(30000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
